// File: rtl/glitch_sweep_ctrl_pkg.sv
// rtl/glitch_sweep_ctrl_pkg.sv - shared states, frame layout and frame helpers
package glitch_pkg;

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, RSTT, RUN, STEP, DONE} state_e;

  // Field layout must match the glitch stage's frame decode.
  localparam int FRAME_W    = 16;
  localparam int GSTART_LSB = 0;
  localparam int GSTOP_LSB  = 4;
  localparam int CLKCNT_LSB = 8;
  localparam int EN_BIT     = 15;

  function automatic logic [3:0] calc_gstop(input logic [3:0] gstart, input logic [3:0] gwidth);
    logic [4:0] sum;
    sum = {1'b0, gstart} + {1'b0, gwidth};
    return sum[4] ? 4'hF : sum[3:0];
  endfunction

  function automatic logic [FRAME_W-1:0] build_frame(input logic [6:0] clkcnt,
                                                     input logic [3:0] gstop,
                                                     input logic [3:0] gstart);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[EN_BIT]           = 1'b1;
    f[CLKCNT_LSB +: 7]  = clkcnt;
    f[GSTOP_LSB +: 4]   = gstop;
    f[GSTART_LSB +: 4]  = gstart;
    return f;
  endfunction

endpackage

// File: rtl/glitch_sweep_ctrl_if.sv
// rtl/glitch_sweep_ctrl_if.sv - sweep control, SPI and target-reset signal bundle
interface glitch_sweep_ctrl_if;
  logic       start;
  logic       stop;
  logic [6:0] clkcnt_min;
  logic [6:0] clkcnt_max;
  logic [3:0] gstart_min;
  logic [3:0] gstart_max;
  logic [3:0] gwidth;
  logic       tgt_ok;
  logic       SPI_NRST;
  logic       SPI_SCK;
  logic       SPI_SDI;
  logic       TGT_NRST;
  logic       busy;
  logic       done;
  logic       hit;
  logic [6:0] cur_clkcnt;
  logic [3:0] cur_gstart;

  modport master (
    output start, stop, clkcnt_min, clkcnt_max, gstart_min, gstart_max, gwidth, tgt_ok,
    input  SPI_NRST, SPI_SCK, SPI_SDI, TGT_NRST, busy, done, hit, cur_clkcnt, cur_gstart
  );

  modport slave (
    input  start, stop, clkcnt_min, clkcnt_max, gstart_min, gstart_max, gwidth, tgt_ok,
    output SPI_NRST, SPI_SCK, SPI_SDI, TGT_NRST, busy, done, hit, cur_clkcnt, cur_gstart
  );
endinterface

// File: rtl/glitch_sweep_ctrl_spi_tx.sv
// rtl/glitch_sweep_ctrl_spi_tx.sv - MSB-first bit-banged frame shifter with SCK divider
module spi_frame_tx
  import glitch_pkg::*;
#(
  parameter int SCK_DIV = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] frame_i,
  output logic               busy_o,
  output logic               last_o,
  output logic               sck_o,
  output logic               sdi_o
);

  localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

  logic               busy_q;
  logic               high_q;
  logic [3:0]         bit_idx_q;
  logic [DW-1:0]      div_q;
  logic [FRAME_W-1:0] sr_q;
  logic               sck_q;
  logic               sdi_q;
  logic               div_end;

  assign div_end = (div_q == DW'(SCK_DIV - 1));
  assign last_o  = busy_q & high_q & (bit_idx_q == 4'd0) & div_end;
  assign busy_o  = busy_q;
  assign sck_o   = sck_q;
  assign sdi_o   = sdi_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      busy_q    <= 1'b0;
      high_q    <= 1'b0;
      bit_idx_q <= 4'd0;
      div_q     <= '0;
      sr_q      <= '0;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
    end else if (load_i) begin
      busy_q    <= 1'b1;
      high_q    <= 1'b0;
      bit_idx_q <= 4'd15;
      div_q     <= '0;
      sr_q      <= frame_i;
      sck_q     <= 1'b0;
      sdi_q     <= frame_i[FRAME_W-1];
    end else if (busy_q) begin
      if (!div_end) begin
        div_q <= div_q + 1'b1;
      end else begin
        div_q <= '0;
        if (!high_q) begin
          high_q <= 1'b1;
          sck_q  <= 1'b1;
        end else if (bit_idx_q == 4'd0) begin
          // Line parks low once the final high phase ends.
          busy_q <= 1'b0;
          high_q <= 1'b0;
          sck_q  <= 1'b0;
          sdi_q  <= 1'b0;
        end else begin
          bit_idx_q <= bit_idx_q - 1'b1;
          high_q    <= 1'b0;
          sck_q     <= 1'b0;
          sr_q      <= {sr_q[FRAME_W-2:0], 1'b0};
          sdi_q     <= sr_q[FRAME_W-2];
        end
      end
    end
  end

endmodule

// File: rtl/glitch_sweep_ctrl.sv
// rtl/glitch_sweep_ctrl.sv - glitch parameter sweep sequencer: config frame, target reset, verdict
module glitch_sweep_ctrl #(
  parameter int SCK_DIV    = 4,
  parameter int RST_HOLD   = 64,
  parameter int RUN_W      = 20,
  parameter int RUN_CYCLES = 500000
) (
  input logic                MCLK,
  input logic                RST,
  glitch_sweep_ctrl_if.slave bus
);
  import glitch_pkg::*;

  localparam logic [RUN_W-1:0] HOLD_LAST = RUN_W'(RST_HOLD - 1);
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(RUN_CYCLES - 1);

  state_e             state_q, state_d;
  logic [RUN_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         cmin_q, cmin_d, cmax_q, cmax_d, cur_c_q, cur_c_d;
  logic [3:0]         gmin_q, gmin_d, gmax_q, gmax_d, gw_q, gw_d, cur_g_q, cur_g_d;
  logic               hit_q, hit_d;
  logic               spi_nrst_q, spi_nrst_d, tgt_nrst_q, tgt_nrst_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               tx_load, tx_clr, tx_busy, tx_last, tx_sck, tx_sdi;
  logic [FRAME_W-1:0] frame;

  assign frame = build_frame(cur_c_q, calc_gstop(cur_g_q, gw_q), cur_g_q);

  spi_frame_tx #(.SCK_DIV(SCK_DIV)) u_tx (
    .clk_i  (MCLK),
    .rst_i  (RST),
    .clr_i  (tx_clr),
    .load_i (tx_load),
    .frame_i(frame),
    .busy_o (tx_busy),
    .last_o (tx_last),
    .sck_o  (tx_sck),
    .sdi_o  (tx_sdi)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmin_d  = cmin_q;
    cmax_d  = cmax_q;
    gmin_d  = gmin_q;
    gmax_d  = gmax_q;
    gw_d    = gw_q;
    cur_c_d = cur_c_q;
    cur_g_d = cur_g_q;
    hit_d   = hit_q;
    tx_load = 1'b0;
    tx_clr  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start && !bus.stop) begin
          cmin_d  = bus.clkcnt_min;
          cmax_d  = bus.clkcnt_max;
          gmin_d  = bus.gstart_min;
          gmax_d  = bus.gstart_max;
          gw_d    = bus.gwidth;
          cur_c_d = bus.clkcnt_min;
          cur_g_d = bus.gstart_min;
          hit_d   = 1'b0;
          cnt_d   = '0;
          state_d = CLR;
        end
      end
      CLR: begin
        if (cnt_q == RUN_W'(1)) begin
          cnt_d   = '0;
          tx_load = 1'b1;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (tx_last || !tx_busy) begin
          cnt_d   = '0;
          state_d = RSTT;
        end
      end
      RSTT: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == RUN_LAST) begin
          cnt_d = '0;
          if (bus.tgt_ok) begin
            hit_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = STEP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STEP: begin
        // Inverted ranges fall out naturally: min > max never increments.
        state_d = CLR;
        cnt_d   = '0;
        if (cur_g_q < gmax_q) begin
          cur_g_d = cur_g_q + 4'd1;
        end else begin
          cur_g_d = gmin_q;
          if (cur_c_q < cmax_q) begin
            cur_c_d = cur_c_q + 7'd1;
          end else begin
            hit_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.stop && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      cur_c_d = cur_c_q;
      cur_g_d = cur_g_q;
      hit_d   = hit_q;
      tx_load = 1'b0;
      tx_clr  = 1'b1;
    end

    spi_nrst_d = !(state_d inside {IDLE, CLR});
    tgt_nrst_d = state_d inside {RUN, STEP, DONE};
    busy_d     = !(state_d inside {IDLE, DONE});
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmin_q     <= '0;
      cmax_q     <= '0;
      gmin_q     <= '0;
      gmax_q     <= '0;
      gw_q       <= '0;
      cur_c_q    <= '0;
      cur_g_q    <= '0;
      hit_q      <= 1'b0;
      spi_nrst_q <= 1'b0;
      tgt_nrst_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmin_q     <= cmin_d;
      cmax_q     <= cmax_d;
      gmin_q     <= gmin_d;
      gmax_q     <= gmax_d;
      gw_q       <= gw_d;
      cur_c_q    <= cur_c_d;
      cur_g_q    <= cur_g_d;
      hit_q      <= hit_d;
      spi_nrst_q <= spi_nrst_d;
      tgt_nrst_q <= tgt_nrst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.SPI_NRST   = spi_nrst_q;
  assign bus.SPI_SCK    = tx_sck;
  assign bus.SPI_SDI    = tx_sdi;
  assign bus.TGT_NRST   = tgt_nrst_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.hit        = hit_q;
  assign bus.cur_clkcnt = cur_c_q;
  assign bus.cur_gstart = cur_g_q;

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// tb/tb_glitch_sweep_ctrl.sv - scoreboard bench for the glitch sweep sequencer
module tb_glitch_sweep_ctrl;

  localparam int SCK_DIV    = 4;
  localparam int RST_HOLD   = 64;
  localparam int RUN_W      = 20;
  localparam int RUN_CYCLES = 40;

  logic MCLK = 1'b0;
  logic RST  = 1'b1;
  logic tgt_ok_r = 1'b0;

  glitch_sweep_ctrl_if bus();

  glitch_sweep_ctrl #(
    .SCK_DIV   (SCK_DIV),
    .RST_HOLD  (RST_HOLD),
    .RUN_W     (RUN_W),
    .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .MCLK(MCLK),
    .RST (RST),
    .bus (bus)
  );

  assign bus.tgt_ok = tgt_ok_r;

  always #5 MCLK = ~MCLK;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frames[$];
  int exp_done[$];
  int attempt_no = 0;
  int hit_target = -1;
  bit done_prev  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge MCLK);
  endtask

  function automatic int outs();
    return int'({bus.SPI_NRST, bus.SPI_SCK, bus.SPI_SDI, bus.TGT_NRST, bus.busy,
                 bus.done, bus.hit, bus.cur_clkcnt, bus.cur_gstart});
  endfunction

  // Response-monitor stand-in: noisy high during non-final run cycles, hit only on the final one.
  always begin
    @(posedge bus.TGT_NRST);
    attempt_no++;
    for (int i = 0; i < RUN_CYCLES; i++) begin
      @(negedge MCLK);
      if (attempt_no == hit_target) tgt_ok_r = (i == RUN_CYCLES - 1);
      else                          tgt_ok_r = (i != RUN_CYCLES - 1);
    end
    @(negedge MCLK);
    tgt_ok_r = 1'b0;
  end

  // Frame monitor: sample SDI half a clock after each SCK rise.
  always begin : frame_mon
    logic [15:0] sh;
    int nb;
    @(posedge bus.SPI_SCK or negedge bus.SPI_NRST);
    if (!bus.SPI_NRST) begin
      nb = 0;
      sh = '0;
    end else begin
      @(negedge MCLK);
      sh = {sh[14:0], bus.SPI_SDI};
      nb++;
      if (nb == 16) begin
        nb = 0;
        check("frame_expected", int'(exp_frames.size() > 0), 1);
        if (exp_frames.size() > 0) check("frame", int'(sh), exp_frames.pop_front());
      end
    end
  end

  // Completion monitor.
  always begin : done_mon
    int e;
    @(negedge MCLK);
    if (bus.done && !done_prev) begin
      check("done_expected", int'(exp_done.size() > 0), 1);
      if (exp_done.size() > 0) begin
        e = exp_done.pop_front();
        check("done_result", int'({bus.hit, bus.cur_clkcnt, bus.cur_gstart}), e);
        check("done_outputs", int'({bus.TGT_NRST, bus.SPI_NRST, bus.busy}), 6);
      end
    end
    done_prev = bus.done;
  end

  task automatic run_sweep(input int cmin, input int cmax, input int gmin, input int gmax,
                           input int w, input int hit_idx, input bit wave);
    int cend, gend, n, lc, lg, gs, t, errs;
    bit h;
    logic [15:0] wf;
    cend = (cmax < cmin) ? cmin : cmax;
    gend = (gmax < gmin) ? gmin : gmax;
    n = 0; h = 0; lc = cend; lg = gmin;
    for (int c = cmin; c <= cend; c++)
      for (int g = gmin; g <= gend; g++)
        if (!h) begin
          n++;
          gs = (g + w > 15) ? 15 : g + w;
          exp_frames.push_back(32768 + c * 256 + gs * 16 + g);
          if (n == hit_idx) begin
            h = 1; lc = c; lg = g;
          end
        end
    exp_done.push_back((int'(h) << 11) | (lc << 4) | lg);
    hit_target = h ? attempt_no + hit_idx : -1;

    bus.clkcnt_min = 7'(cmin);
    bus.clkcnt_max = 7'(cmax);
    bus.gstart_min = 4'(gmin);
    bus.gstart_max = 4'(gmax);
    bus.gwidth     = 4'(w);
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.clkcnt_min = 7'($urandom);
    bus.clkcnt_max = 7'($urandom);
    bus.gstart_min = 4'($urandom);
    bus.gstart_max = 4'($urandom);
    bus.gwidth     = 4'($urandom);

    if (wave) begin
      wf = 16'h8553;
      t = 0;
      while (!bus.SPI_NRST && t < 20) begin tick(); t++; end
      check("clr_cycles", t, 2);
      errs = 0;
      for (int k = 0; k < 32 * SCK_DIV; k++) begin
        if (bus.SPI_SCK != ((k / SCK_DIV) % 2)) errs++;
        if (bus.SPI_SDI != wf[15 - k / (2 * SCK_DIV)]) errs++;
        tick();
      end
      check("sck_sdi_wave_errors", errs, 0);
      check("post_shift_sck_sdi", int'({bus.SPI_SCK, bus.SPI_SDI}), 0);
      t = 0;
      while (!bus.TGT_NRST && t < 200) begin tick(); t++; end
      check("tgt_nrst_low_cycles", t, RST_HOLD);
    end

    t = 0;
    while (exp_done.size() != 0 && t < n * 400 + 500) begin tick(); t++; end
    check("sweep_completed", exp_done.size(), 0);
    repeat (3) tick();
    check("frames_consumed", exp_frames.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, cmin, cmax, gmin, gmax;
    bus.start = 1'b0; bus.stop = 1'b0;
    bus.clkcnt_min = '0; bus.clkcnt_max = '0;
    bus.gstart_min = '0; bus.gstart_max = '0; bus.gwidth = '0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    check("reset_outputs", outs(), 0);

    run_sweep(5, 5, 3, 3, 2, 0, 1'b1);
    check("done_busy_after_single", int'({bus.done, bus.busy, bus.hit}), 4);
    run_sweep(10, 11, 14, 15, 3, 0, 1'b0);
    run_sweep(10, 11, 14, 15, 3, 2, 1'b0);
    check("hit_tgt_nrst", int'({bus.hit, bus.TGT_NRST}), 3);
    run_sweep(0, 1, 9, 2, 5, 0, 1'b0);

    repeat (4) begin
      cmin = $urandom_range(0, 126);
      cmax = ($urandom_range(0, 3) == 0) ? $urandom_range(0, cmin) : cmin + $urandom_range(0, 1);
      gmin = $urandom_range(0, 15);
      gmax = ($urandom_range(0, 1) == 0) ? $urandom_range(0, gmin) : gmin + $urandom_range(0, 2);
      if (gmax > 15) gmax = 15;
      run_sweep(cmin, cmax, gmin, gmax, $urandom_range(0, 15), $urandom_range(0, 4), 1'b0);
    end

    // Abort mid-SHIFT around bit 7.
    hit_target = -1;
    bus.clkcnt_min = 7'd5; bus.clkcnt_max = 7'd5;
    bus.gstart_min = 4'd3; bus.gstart_max = 4'd3; bus.gwidth = 4'd2;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    t = 0;
    while (!bus.SPI_NRST && t < 20) begin tick(); t++; end
    repeat (7 * 2 * SCK_DIV + 2) tick();
    check("busy_mid_shift", int'(bus.busy), 1);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    check("stop_outputs", int'({bus.SPI_NRST, bus.SPI_SCK, bus.SPI_SDI, bus.TGT_NRST, bus.busy, bus.done}), 0);
    check("stop_keeps_cur", int'({bus.cur_clkcnt, bus.cur_gstart}), (5 << 4) | 3);
    repeat (5) tick();
    check("no_frame_after_stop", exp_frames.size(), 0);
    run_sweep(5, 5, 3, 4, 2, 0, 1'b0);

    // RST during RUN.
    hit_target = -1;
    exp_frames.push_back(32768 + 20 * 256 + 8 * 16 + 7);
    bus.clkcnt_min = 7'd20; bus.clkcnt_max = 7'd20;
    bus.gstart_min = 4'd7; bus.gstart_max = 4'd7; bus.gwidth = 4'd1;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    t = 0;
    while (!bus.TGT_NRST && t < 400) begin tick(); t++; end
    check("reached_run", int'(bus.TGT_NRST), 1);
    repeat (10) tick();
    RST = 1'b1; tick();
    check("rst_outputs", outs(), 0);
    RST = 1'b0; tick();
    check("rst_frames_consumed", exp_frames.size(), 0);

    // start and stop together from IDLE.
    bus.start = 1'b1; bus.stop = 1'b1; tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    check("start_stop_outputs", outs(), 0);
    repeat (12) tick();
    check("start_stop_stays_idle", int'({bus.SPI_NRST, bus.busy, bus.done}), 0);

    repeat (5) tick();
    check("final_done_queue", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
